// File: rtl/conv_pkg.sv
// Shared types for the conv layer: arbiter mode and phase scheduler state.
package conv_pkg;

   typedef enum logic [1:0] {
      ModeConvolution = 2'd0,
      ModePooling     = 2'd1
   } arbiter_mode_t;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StConv      = 3'd1,
      StConvDrain = 3'd2,
      StPoolStart = 3'd3,
      StPool      = 3'd4,
      StPause     = 3'd5
   } sched_state_t;

endpackage

// File: rtl/conv_phase_scheduler.sv
// Per-timestep sequencer: convolution, pipeline drain, pooling start, pooling,
// with a watchdog that parks the layer in a sticky fault state.
module conv_phase_scheduler
   import conv_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES    = 4,
   parameter int unsigned WATCHDOG_CYCLES = 65535,
   parameter int unsigned TS_COUNT_WIDTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable_i,
   input  logic                      timestep_seen_i,
   input  logic                      conv_active_i,
   input  logic                      pool_done_i,
   input  logic                      out_fifo_full_nx_i,
   output logic                      capture_enable_o,
   output logic                      pool_enable_o,
   output logic                      pool_stall_o,
   output arbiter_mode_t             arbiter_mode_o,
   output logic [TS_COUNT_WIDTH-1:0] ts_count_o,
   output logic                      busy_o,
   output logic                      fault_o
);

   localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int unsigned WdW    = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
   localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);
   localparam logic [WdW-1:0]    WdLast    = WdW'(WATCHDOG_CYCLES - 1);

   sched_state_t              state_q, state_d;
   arbiter_mode_t             mode_q, mode_d;
   logic [DrainW-1:0]         drain_cnt_q, drain_cnt_d;
   logic [WdW-1:0]            wd_cnt_q, wd_cnt_d;
   logic [TS_COUNT_WIDTH-1:0] ts_q, ts_d;
   logic                      fault_q, fault_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         mode_q      <= ModeConvolution;
         drain_cnt_q <= '0;
         wd_cnt_q    <= '0;
         ts_q        <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         drain_cnt_q <= drain_cnt_d;
         wd_cnt_q    <= wd_cnt_d;
         ts_q        <= ts_d;
         fault_q     <= fault_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      drain_cnt_d = drain_cnt_q;
      wd_cnt_d    = wd_cnt_q;
      ts_d        = ts_q;
      fault_d     = fault_q;

      if (enable_i) begin
         unique case (state_q)
            StIdle: state_d = StConv;
            StConv: begin
               if (timestep_seen_i) state_d = StConvDrain;
            end
            StConvDrain: begin
               drain_cnt_d = conv_active_i ? '0 : drain_cnt_q + DrainW'(1);
               wd_cnt_d    = wd_cnt_q + WdW'(1);
               // A completed drain takes priority over a simultaneous expiry.
               if (!conv_active_i && drain_cnt_q == DrainLast) begin
                  state_d = StPoolStart;
                  mode_d  = ModePooling;
               end else if (wd_cnt_q == WdLast) begin
                  state_d = StPause;
                  mode_d  = ModeConvolution;
                  fault_d = 1'b1;
               end
            end
            StPoolStart: state_d = StPool;
            StPool: begin
               wd_cnt_d = wd_cnt_q + WdW'(1);
               if (pool_done_i) begin
                  state_d = StConv;
                  mode_d  = ModeConvolution;
                  ts_d    = ts_q + TS_COUNT_WIDTH'(1);
               end else if (wd_cnt_q == WdLast) begin
                  state_d = StPause;
                  mode_d  = ModeConvolution;
                  fault_d = 1'b1;
               end
            end
            StPause: state_d = StPause;
            default: state_d = StIdle;
         endcase

         if (state_d != state_q) begin
            drain_cnt_d = '0;
            wd_cnt_d    = '0;
         end
      end
   end

   always_comb begin
      capture_enable_o = (state_q == StConv) && enable_i;
      pool_enable_o    = (state_q == StPoolStart) && enable_i;
      pool_stall_o     = (state_q == StPool) && out_fifo_full_nx_i;
      busy_o           = !((state_q == StIdle) || (state_q == StConv));
      arbiter_mode_o   = mode_q;
      ts_count_o       = ts_q;
      fault_o          = fault_q;
   end

endmodule

// File: tb/tb_conv_phase_scheduler.sv
// Directed bench for conv_phase_scheduler with DRAIN_CYCLES=3, WATCHDOG_CYCLES=64,
// TS_COUNT_WIDTH=4. Inputs change and outputs are sampled around the falling edge.
module tb_conv_phase_scheduler;
   import conv_pkg::*;

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic          timestep_seen;
   logic          conv_active;
   logic          pool_done;
   logic          out_fifo_full_nx;
   logic          capture_enable;
   logic          pool_enable;
   logic          pool_stall;
   arbiter_mode_t arbiter_mode;
   logic [3:0]    ts_count;
   logic          busy;
   logic          fault;

   int tests_run = 0;
   int tests_failed = 0;

   conv_phase_scheduler #(
      .DRAIN_CYCLES   (3),
      .WATCHDOG_CYCLES(64),
      .TS_COUNT_WIDTH (4)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .enable_i          (enable),
      .timestep_seen_i   (timestep_seen),
      .conv_active_i     (conv_active),
      .pool_done_i       (pool_done),
      .out_fifo_full_nx_i(out_fifo_full_nx),
      .capture_enable_o  (capture_enable),
      .pool_enable_o     (pool_enable),
      .pool_stall_o      (pool_stall),
      .arbiter_mode_o    (arbiter_mode),
      .ts_count_o        (ts_count),
      .busy_o            (busy),
      .fault_o           (fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Pulses timestep_seen in a CONV cycle and waits for the pooling start pulse.
   task automatic start_pool();
      bit seen;
      seen = 1'b0;
      cyc();
      timestep_seen = 1'b1;
      conv_active   = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc();
         timestep_seen = 1'b0;
         #1;
         if (pool_enable) seen = 1'b1;
      end
      chk("pool_start_seen", 32'(seen), 32'd1);
   endtask

   task automatic do_ts();
      start_pool();
      cyc();
      pool_done = 1'b1;
      cyc();
      pool_done = 1'b0;
   endtask

   initial begin
      rst_n            = 1'b1;
      enable           = 1'b0;
      timestep_seen    = 1'b0;
      conv_active      = 1'b0;
      pool_done        = 1'b0;
      out_fifo_full_nx = 1'b0;
      #3 rst_n = 1'b0;
      cyc();
      cyc();
      enable = 1'b1;
      #1;
      chk("rst_capture", 32'(capture_enable), 32'd0);
      chk("rst_pool_en", 32'(pool_enable), 32'd0);
      chk("rst_stall", 32'(pool_stall), 32'd0);
      chk("rst_mode", 32'(arbiter_mode), 32'(ModeConvolution));
      chk("rst_ts", 32'(ts_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);

      // Cycle 1 after release: CONV.
      rst_n = 1'b1;
      cyc();
      #1;
      chk("c1_capture", 32'(capture_enable), 32'd1);
      chk("c1_mode", 32'(arbiter_mode), 32'(ModeConvolution));
      chk("c1_ts", 32'(ts_count), 32'd0);

      // t: timestep_seen with conv_active high through t+5.
      timestep_seen = 1'b1;
      conv_active   = 1'b1;
      #1;
      chk("t_capture", 32'(capture_enable), 32'd1);
      cyc();
      timestep_seen = 1'b0;
      #1;
      chk("t1_capture_fall", 32'(capture_enable), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);
      repeat (4) cyc();
      #1;
      chk("t5_pool_en", 32'(pool_enable), 32'd0);
      cyc();
      conv_active = 1'b0;
      cyc();
      cyc();
      #1;
      chk("t8_pool_en", 32'(pool_enable), 32'd0);
      chk("t8_mode", 32'(arbiter_mode), 32'(ModeConvolution));
      cyc();
      #1;
      chk("t9_pool_en", 32'(pool_enable), 32'd1);
      chk("t9_mode", 32'(arbiter_mode), 32'(ModePooling));
      cyc();
      out_fifo_full_nx = 1'b1;
      #1;
      chk("t10_pool_en", 32'(pool_enable), 32'd0);
      chk("t10_stall_hi", 32'(pool_stall), 32'd1);
      cyc();
      out_fifo_full_nx = 1'b0;
      #1;
      chk("t11_stall_lo", 32'(pool_stall), 32'd0);
      repeat (17) cyc();
      cyc();
      pool_done = 1'b1;
      #1;
      chk("t29_ts", 32'(ts_count), 32'd0);
      chk("t29_mode", 32'(arbiter_mode), 32'(ModePooling));
      cyc();
      pool_done        = 1'b0;
      out_fifo_full_nx = 1'b1;
      #1;
      chk("t30_capture", 32'(capture_enable), 32'd1);
      chk("t30_mode", 32'(arbiter_mode), 32'(ModeConvolution));
      chk("t30_ts", 32'(ts_count), 32'd1);
      chk("t30_stall_conv", 32'(pool_stall), 32'd0);
      chk("t30_busy", 32'(busy), 32'd0);
      out_fifo_full_nx = 1'b0;

      // pool_done outside POOL is ignored.
      cyc();
      pool_done = 1'b1;
      cyc();
      pool_done = 1'b0;
      #1;
      chk("stray_done_ts", 32'(ts_count), 32'd1);
      chk("stray_done_capture", 32'(capture_enable), 32'd1);

      // Timestep counter wrap.
      repeat (14) do_ts();
      #1;
      chk("ts_15", 32'(ts_count), 32'd15);
      do_ts();
      #1;
      chk("ts_wrap", 32'(ts_count), 32'd0);
      do_ts();
      #1;
      chk("ts_after_wrap", 32'(ts_count), 32'd1);

      // timestep_seen while disabled is lost.
      cyc();
      enable        = 1'b0;
      timestep_seen = 1'b1;
      #1;
      chk("dis_capture", 32'(capture_enable), 32'd0);
      cyc();
      enable        = 1'b1;
      timestep_seen = 1'b0;
      #1;
      chk("lost_pulse_capture", 32'(capture_enable), 32'd1);
      chk("lost_pulse_busy", 32'(busy), 32'd0);

      // Freeze during CONV_DRAIN: one drain count, ten disabled cycles, then two more.
      cyc();
      timestep_seen = 1'b1;
      conv_active   = 1'b0;
      cyc();
      timestep_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         enable      = 1'b0;
         conv_active = 1'b1;
         #1;
         chk("frz_pool_en", 32'(pool_enable), 32'd0);
      end
      chk("frz_busy", 32'(busy), 32'd1);
      chk("frz_capture", 32'(capture_enable), 32'd0);
      cyc();
      enable      = 1'b1;
      conv_active = 1'b0;
      #1;
      chk("frz_e1_pool_en", 32'(pool_enable), 32'd0);
      cyc();
      #1;
      chk("frz_e2_pool_en", 32'(pool_enable), 32'd0);
      cyc();
      #1;
      chk("frz_e3_pool_en", 32'(pool_enable), 32'd1);

      // Asynchronous reset mid-POOL.
      cyc();
      out_fifo_full_nx = 1'b1;
      #1;
      chk("pool_mode", 32'(arbiter_mode), 32'(ModePooling));
      chk("pool_stall", 32'(pool_stall), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_stall", 32'(pool_stall), 32'd0);
      chk("arst_mode", 32'(arbiter_mode), 32'(ModeConvolution));
      chk("arst_ts", 32'(ts_count), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_capture", 32'(capture_enable), 32'd0);

      // Watchdog in POOL.
      cyc();
      rst_n            = 1'b1;
      out_fifo_full_nx = 1'b0;
      start_pool();
      for (int i = 0; i <= 66; i++) begin
         cyc();
         #1;
         if (i == 62) begin
            chk("wd_pre_fault", 32'(fault), 32'd0);
            chk("wd_pre_mode", 32'(arbiter_mode), 32'(ModePooling));
         end
      end
      chk("wd_fault", 32'(fault), 32'd1);
      chk("wd_capture", 32'(capture_enable), 32'd0);
      chk("wd_mode", 32'(arbiter_mode), 32'(ModeConvolution));
      chk("wd_busy", 32'(busy), 32'd1);
      cyc();
      timestep_seen = 1'b1;
      pool_done     = 1'b1;
      cyc();
      timestep_seen = 1'b0;
      pool_done     = 1'b0;
      repeat (3) cyc();
      #1;
      chk("pause_fault", 32'(fault), 32'd1);
      chk("pause_capture", 32'(capture_enable), 32'd0);
      chk("pause_pool_en", 32'(pool_enable), 32'd0);
      chk("pause_mode", 32'(arbiter_mode), 32'(ModeConvolution));
      chk("pause_ts", 32'(ts_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
